// File: rtl/axis_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : axis_packetizer
// Purpose  : Buffers an AXI-Stream sample stream in a FIFO and delimits it
//            into frames of frame_length beats marked with M_AXIS_tlast.
// Option   : AXIS_PACKETIZER_DROP_EN - drop samples instead of stalling when full
// Revision : 1.0 - initial release
// ============================================================================
module axis_packetizer #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int LOG_DEPTH        = 4
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        enable,
  input  logic [15:0]                 frame_length,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                        S_AXIS_tvalid,
  output logic                        S_AXIS_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                        M_AXIS_tvalid,
  input  logic                        M_AXIS_tready,
  output logic                        M_AXIS_tlast,
  output logic [LOG_DEPTH:0]          fill_level,
  output logic [31:0]                 frame_count,
  output logic [31:0]                 overflow_count
);

  localparam int DEPTH = 2 ** LOG_DEPTH;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_FRAME = 1'b1} state_t;

  state_t                      state_q, state_d;
  logic [15:0]                 len_q, len_d;
  logic [15:0]                 beat_q, beat_d;
  logic [LOG_DEPTH:0]          wr_ptr_q, rd_ptr_q;
  logic [AXIS_TDATA_WIDTH:0]   mem [DEPTH];
  logic [AXIS_TDATA_WIDTH-1:0] out_data_q;
  logic                        out_valid_q;
  logic                        out_last_q;
  logic [31:0]                 frame_cnt_q;

  logic [LOG_DEPTH:0] mem_cnt;
  logic [15:0]        len_new;
  logic               mem_empty, full, in_frame, wr_en, wr_last;
  logic               out_free, pop, bypass;

  assign mem_cnt    = wr_ptr_q - rd_ptr_q;
  assign mem_empty  = (wr_ptr_q == rd_ptr_q);
  // Occupancy includes the output register so capacity is exactly DEPTH words.
  assign fill_level = mem_cnt + (LOG_DEPTH + 1)'(out_valid_q);
  assign full       = (fill_level == (LOG_DEPTH + 1)'(DEPTH));
  assign in_frame   = (state_q == S_FRAME);
  assign wr_en      = in_frame & S_AXIS_tvalid & ~full;
  assign wr_last    = (beat_q == len_q - 16'd1);
  assign len_new    = (frame_length == 16'd0) ? 16'd1 : frame_length;
  assign out_free   = ~out_valid_q | M_AXIS_tready;
  assign pop        = out_free & ~mem_empty;
  assign bypass     = out_free & mem_empty & wr_en;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    beat_d  = beat_q;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_FRAME;
          len_d   = len_new;
          beat_d  = 16'd0;
        end
      end
      S_FRAME: begin
        if (wr_en) begin
          if (wr_last) begin
            beat_d = 16'd0;
            if (enable) len_d = len_new;
            else        state_d = S_IDLE;
          end else begin
            beat_d = beat_q + 16'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= S_IDLE;
      len_q   <= 16'd1;
      beat_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (wr_en && !bypass) mem[wr_ptr_q[LOG_DEPTH-1:0]] <= {wr_last, S_AXIS_tdata};
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      frame_cnt_q <= 32'd0;
    end else begin
      if (wr_en && !bypass) wr_ptr_q <= wr_ptr_q + 1'b1;
      // Empty FIFO: a fresh write goes straight to the output register.
      if (out_free) begin
        if (pop) begin
          {out_last_q, out_data_q} <= mem[rd_ptr_q[LOG_DEPTH-1:0]];
          rd_ptr_q    <= rd_ptr_q + 1'b1;
          out_valid_q <= 1'b1;
        end else if (wr_en) begin
          {out_last_q, out_data_q} <= {wr_last, S_AXIS_tdata};
          out_valid_q <= 1'b1;
        end else begin
          out_valid_q <= 1'b0;
        end
      end
      if (out_valid_q && M_AXIS_tready && out_last_q) frame_cnt_q <= frame_cnt_q + 32'd1;
    end
  end

  assign M_AXIS_tdata  = out_data_q;
  assign M_AXIS_tvalid = out_valid_q;
  assign M_AXIS_tlast  = out_last_q;
  assign frame_count   = frame_cnt_q;

`ifdef AXIS_PACKETIZER_DROP_EN
  logic [31:0] ovf_q;

  assign S_AXIS_tready = in_frame;

  always_ff @(posedge aclk) begin
    if (areset) begin
      ovf_q <= 32'd0;
    end else if (in_frame && S_AXIS_tvalid && full && (ovf_q != 32'hFFFF_FFFF)) begin
      ovf_q <= ovf_q + 32'd1;
    end
  end

  assign overflow_count = ovf_q;
`else
  assign S_AXIS_tready  = in_frame & ~full;
  assign overflow_count = 32'd0;
`endif

endmodule
`default_nettype wire
